// File: rtl/pixel_pack_word.sv
// pixel_pack_word: serial-to-parallel pixel packer.
// Collects IN_W-bit beats into OUT_W-bit words (MSB-first or LSB-first),
// supports frame-start realignment (in_sof), partial-word flush (in_flush)
// and a registered, backpressured output word.
// Optional statistics counters are built when PIXEL_PACK_STAT_EN is defined;
// otherwise stat_words/stat_drops are tied to zero.
module pixel_pack_word #(
    parameter int IN_W      = 1,
    parameter int OUT_W     = 16,
    parameter int MSB_FIRST = 1
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [IN_W-1:0]                      in_data,
    input  logic                                 in_sof,
    input  logic                                 in_flush,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [OUT_W-1:0]                     out_data,
    output logic [$clog2(OUT_W/IN_W+1)-1:0]      out_cnt,
    output logic                                 out_last,
    output logic                                 sync_err,
    output logic [31:0]                          stat_words,
    output logic [15:0]                          stat_drops
);

    localparam int BEATS  = OUT_W / IN_W;
    localparam int CNT_W  = ($clog2(BEATS) > 1) ? $clog2(BEATS) : 1;
    localparam int OCNT_W = $clog2(BEATS + 1);
    localparam logic [CNT_W-1:0] LAST_POS = CNT_W'(BEATS - 1);

    logic [CNT_W-1:0]  cnt;
    logic [OUT_W-1:0]  acc;
    logic [CNT_W-1:0]  pos;
    logic [OUT_W-1:0]  beat_word;
    logic [OUT_W-1:0]  merged;
    logic              free;
    logic              accept;
    logic              complete;
    logic              drop;

    // Handshake, beat position and word-completion decode.
    always_comb begin
        free     = !out_valid || out_ready;
        in_ready = free || (!in_flush && (cnt != LAST_POS));
        accept   = in_valid && in_ready;
        pos      = in_sof ? '0 : cnt;
        complete = accept && (in_flush || (pos == LAST_POS));
        // A sof beat on a non-empty accumulator throws the partial word away.
        drop     = accept && in_sof && (cnt != '0);
    end

    // Place the incoming beat at its slot and merge with the accumulator.
    always_comb begin
        beat_word = '0;
        for (int k = 0; k < BEATS; k++) begin
            if (pos == CNT_W'(k)) begin
                if (MSB_FIRST != 0) begin
                    beat_word[OUT_W-1-k*IN_W -: IN_W] = in_data;
                end else begin
                    beat_word[k*IN_W +: IN_W] = in_data;
                end
            end
        end
        merged = (in_sof ? '0 : acc) | beat_word;
    end

    // Accumulator, beat counter and registered output word.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            acc       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_cnt   <= '0;
            out_last  <= 1'b0;
            sync_err  <= 1'b0;
        end else begin
            sync_err <= drop;
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (complete) begin
                out_valid <= 1'b1;
                out_data  <= merged;
                out_cnt   <= OCNT_W'(pos) + OCNT_W'(1);
                out_last  <= in_flush;
                acc       <= '0;
                cnt       <= '0;
            end else if (accept) begin
                acc <= merged;
                cnt <= pos + CNT_W'(1);
            end
        end
    end

`ifdef PIXEL_PACK_STAT_EN
    // Saturating counts of delivered words and of discarded partial words.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_words <= '0;
            stat_drops <= '0;
        end else begin
            if (out_valid && out_ready && (stat_words != 32'hFFFF_FFFF)) begin
                stat_words <= stat_words + 32'd1;
            end
            if (drop && (stat_drops != 16'hFFFF)) begin
                stat_drops <= stat_drops + 16'd1;
            end
        end
    end
`else
    assign stat_words = '0;
    assign stat_drops = '0;
`endif

endmodule

// File: tb/tb_pixel_pack_word.sv
// Self-checking bench for pixel_pack_word: directed bit-packer sequences,
// a table of nibble-packer words, and a randomized scoreboard run.
module tb_pixel_pack_word;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // 1-bit to 8-bit packers (MSB-first u_a, LSB-first u_b) sharing inputs
    logic       a_valid = 0, a_data = 0, a_sof = 0, a_flush = 0, a_oready = 1;
    logic       a_ready, a_ovalid, a_olast, a_serr;
    logic [7:0] a_odata;
    logic [3:0] a_ocnt;
    logic [31:0] a_sw;
    logic [15:0] a_sd;
    logic       b_ready, b_ovalid, b_olast, b_serr;
    logic [7:0] b_odata;
    logic [3:0] b_ocnt;
    logic [31:0] b_sw;
    logic [15:0] b_sd;

    // 4-bit to 16-bit MSB-first packer
    logic        c_valid = 0, c_sof = 0, c_flush = 0, c_oready = 1;
    logic [3:0]  c_data = 0;
    logic        c_ready, c_ovalid, c_olast, c_serr;
    logic [15:0] c_odata;
    logic [2:0]  c_ocnt;
    logic [31:0] c_sw;
    logic [15:0] c_sd;

    pixel_pack_word #(.IN_W(1), .OUT_W(8), .MSB_FIRST(1)) u_a (
        .clk(clk), .rst(rst), .in_valid(a_valid), .in_ready(a_ready), .in_data(a_data),
        .in_sof(a_sof), .in_flush(a_flush), .out_valid(a_ovalid), .out_ready(a_oready),
        .out_data(a_odata), .out_cnt(a_ocnt), .out_last(a_olast), .sync_err(a_serr),
        .stat_words(a_sw), .stat_drops(a_sd));

    pixel_pack_word #(.IN_W(1), .OUT_W(8), .MSB_FIRST(0)) u_b (
        .clk(clk), .rst(rst), .in_valid(a_valid), .in_ready(b_ready), .in_data(a_data),
        .in_sof(a_sof), .in_flush(a_flush), .out_valid(b_ovalid), .out_ready(a_oready),
        .out_data(b_odata), .out_cnt(b_ocnt), .out_last(b_olast), .sync_err(b_serr),
        .stat_words(b_sw), .stat_drops(b_sd));

    pixel_pack_word #(.IN_W(4), .OUT_W(16), .MSB_FIRST(1)) u_c (
        .clk(clk), .rst(rst), .in_valid(c_valid), .in_ready(c_ready), .in_data(c_data),
        .in_sof(c_sof), .in_flush(c_flush), .out_valid(c_ovalid), .out_ready(c_oready),
        .out_data(c_odata), .out_cnt(c_ocnt), .out_last(c_olast), .sync_err(c_serr),
        .stat_words(c_sw), .stat_drops(c_sd));

    task automatic a_beat(input logic d, input logic sof, input logic flush);
        a_valid = 1; a_data = d; a_sof = sof; a_flush = flush;
        @(posedge clk); #1;
        a_valid = 0; a_sof = 0; a_flush = 0;
    endtask

    task automatic c_beat(input logic [3:0] d, input logic sof, input logic flush);
        c_valid = 1; c_data = d; c_sof = sof; c_flush = flush;
        @(posedge clk); #1;
        c_valid = 0; c_sof = 0; c_flush = 0;
    endtask

    task automatic a_byte(input logic [7:0] bits);
        for (int i = 0; i < 8; i++) a_beat(bits[7-i], 1'b0, 1'b0);
    endtask

    // Table of nibble-packer words
    typedef struct {
        int          n;
        logic [15:0] beats;
        logic        sof0;
        logic        flush_last;
        logic [15:0] exp_data;
        int          exp_cnt;
        logic        exp_last;
    } vec_t;
    vec_t tbl[5];

    // Reference model state for the randomized run
    typedef struct { int d; int c; logic l; } wd_t;
    wd_t  expq[$];
    int   plen;
    int   pb[4];
    int   hs_cnt, drop_cnt;
    logic exp_serr;

    task automatic c_cycle();
        logic nxt_serr;
        int   word;
        wd_t  w;
        @(negedge clk);
        check("rnd_sync_err", c_serr, exp_serr);
        nxt_serr = 0;
        if (c_valid && !c_flush && plen != 3) check("rnd_ready_nostall", c_ready, 1);
        if (c_ovalid && c_oready) begin
            hs_cnt++;
            if (expq.size() == 0) begin
                n_total++;
                $display("FAIL rnd_spurious_word: got data 0x%0h with no word expected", c_odata);
            end else begin
                w = expq.pop_front();
                check("rnd_data", c_odata, w.d);
                check("rnd_cnt", c_ocnt, w.c);
                check("rnd_last", c_olast, w.l);
            end
        end
        if (c_valid && c_ready) begin
            if (c_sof) begin
                if (plen != 0) begin nxt_serr = 1; drop_cnt++; end
                plen = 0;
            end
            pb[plen] = c_data;
            plen++;
            if (c_flush || plen == 4) begin
                word = 0;
                for (int k = 0; k < plen; k++) word = word + pb[k] * (16 ** (3 - k));
                w.d = word; w.c = plen; w.l = c_flush;
                expq.push_back(w);
                plen = 0;
            end
        end
        @(posedge clk); #1;
        exp_serr = nxt_serr;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        tbl[0] = '{4, 16'hABCD, 0, 0, 16'hABCD, 4, 0};
        tbl[1] = '{4, 16'h1234, 0, 0, 16'h1234, 4, 0};
        tbl[2] = '{2, 16'h5600, 0, 1, 16'h5600, 2, 1};
        tbl[3] = '{1, 16'hF000, 1, 1, 16'hF000, 1, 1};
        tbl[4] = '{3, 16'h9870, 0, 1, 16'h9870, 3, 1};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_ovalid", a_ovalid, 0);
        check("rst_odata", a_odata, 0);
        check("rst_ocnt", a_ocnt, 0);
        check("rst_olast", a_olast, 0);
        check("rst_serr", a_serr, 0);
        check("rst_stat_words", a_sw, 0);
        check("rst_stat_drops", a_sd, 0);
        check("rst_c_ovalid", c_ovalid, 0);
        check("rst_c_odata", c_odata, 0);
        check("rst_ready", a_ready, 1);
        check("rst_b_ready", b_ready, 1);
        rst = 0;

        // Full byte, both bit orders; out_valid exactly one cycle
        a_oready = 1;
        for (int i = 0; i < 8; i++) begin
            a_beat(w_bit(8'hB2, i), 0, 0);
            if (i == 6) check("t1_no_early_valid", a_ovalid, 0);
        end
        check("t1_ovalid", a_ovalid, 1);
        check("t1_msb_data", a_odata, 8'hB2);
        check("t1_ocnt", a_ocnt, 8);
        check("t1_olast", a_olast, 0);
        check("t1_b_ovalid", b_ovalid, 1);
        check("t1_lsb_data", b_odata, 8'h4D);
        @(posedge clk); #1;
        check("t1_valid_one_cycle", a_ovalid, 0);

        // Flush of a 3-beat partial word, then a full word from position 0
        a_beat(1, 0, 0); a_beat(1, 0, 0); a_beat(1, 0, 1);
        check("flush_msb_data", a_odata, 8'hE0);
        check("flush_ocnt", a_ocnt, 3);
        check("flush_olast", a_olast, 1);
        check("flush_lsb_data", b_odata, 8'h07);
        check("flush_b_ocnt", b_ocnt, 3);
        check("flush_b_olast", b_olast, 1);
        a_byte(8'hB2);
        check("after_flush_data", a_odata, 8'hB2);
        check("after_flush_ocnt", a_ocnt, 8);
        check("after_flush_olast", a_olast, 0);
        @(posedge clk); #1;

        // Backpressure
        a_oready = 0;
        a_byte(8'hB2);
        check("bp_hold_valid", a_ovalid, 1);
        for (int i = 0; i < 7; i++) begin
            a_valid = 1; a_data = w_bit(8'h55, i);
            #1;
            check("bp_ready_noncompleting", a_ready, 1);
            @(posedge clk); #1;
        end
        a_valid = 1; a_data = w_bit(8'h55, 7);
        #1;
        check("bp_ready_completing", a_ready, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("bp_ready_still_low", a_ready, 0);
        check("bp_data_stable", a_odata, 8'hB2);
        check("bp_valid_stable", a_ovalid, 1);
        a_oready = 1;
        #1;
        check("bp_ready_released", a_ready, 1);
        @(posedge clk); #1;
        a_oready = 0; a_valid = 0;
        check("bp_new_valid", a_ovalid, 1);
        check("bp_new_data", a_odata, 8'h55);
        a_oready = 1;
        @(posedge clk); #1;
        check("bp_valid_falls", a_ovalid, 0);

        // sof after 5 beats
        for (int i = 0; i < 5; i++) a_beat(1, 0, 0);
        a_beat(0, 1, 0);
        check("sof_serr_pulse", a_serr, 1);
        check("sof_b_serr_pulse", b_serr, 1);
        @(posedge clk); #1;
        check("sof_serr_one_cycle", a_serr, 0);
`ifdef PIXEL_PACK_STAT_EN
        check("sof_stat_drops", a_sd, 1);
`else
        check("sof_stat_drops", a_sd, 0);
`endif
        for (int i = 0; i < 7; i++) a_beat(1, 0, 0);
        check("sof_word_msb", a_odata, 8'h7F);
        check("sof_word_lsb", b_odata, 8'hFE);
        check("sof_word_ocnt", a_ocnt, 8);
        @(posedge clk); #1;

        // Nibble-packer table
        c_oready = 1;
        foreach (tbl[t]) begin
            for (int k = 0; k < tbl[t].n; k++)
                c_beat(tbl[t].beats[15-4*k -: 4], tbl[t].sof0 && (k == 0),
                       tbl[t].flush_last && (k == tbl[t].n - 1));
            w = 0;
            while (!c_ovalid && w < 4) begin @(posedge clk); #1; w++; end
            check("tbl_valid", c_ovalid, 1);
            check("tbl_data", c_odata, tbl[t].exp_data);
            check("tbl_cnt", c_ocnt, tbl[t].exp_cnt);
            check("tbl_last", c_olast, tbl[t].exp_last);
            @(posedge clk); #1;
        end

        // Reset mid-word discards the partial word
        c_beat(4'h5, 0, 0); c_beat(4'h6, 0, 0);
        check("rstmid_no_word", c_ovalid, 0);
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        check("rstmid_ovalid", c_ovalid, 0);
        check("rstmid_ocnt", c_ocnt, 0);
        c_beat(4'h1, 0, 0); c_beat(4'h2, 0, 0); c_beat(4'h3, 0, 0); c_beat(4'h4, 0, 0);
        check("rstmid_next_data", c_odata, 16'h1234);
        check("rstmid_next_cnt", c_ocnt, 4);
        @(posedge clk); #1;

        // Randomized run against the reference model
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        plen = 0; exp_serr = 0; hs_cnt = 0; drop_cnt = 0;
        expq.delete();
        for (int i = 0; i < 800; i++) begin
            c_valid  = ($urandom_range(0, 9) < 7);
            c_data   = 4'($urandom);
            c_sof    = ($urandom_range(0, 9) == 0);
            c_flush  = ($urandom_range(0, 9) == 0);
            c_oready = ($urandom_range(0, 9) < 6);
            c_cycle();
        end
        c_valid = 0; c_sof = 0; c_flush = 0; c_oready = 1;
        repeat (3) c_cycle();
        check("rnd_drained", expq.size(), 0);
`ifdef PIXEL_PACK_STAT_EN
        check("rnd_stat_words", c_sw, hs_cnt);
        check("rnd_stat_drops", c_sd, drop_cnt);
`else
        check("rnd_stat_words", c_sw, 0);
        check("rnd_stat_drops", c_sd, 0);
`endif
        check("a_stat_words_cleared", a_sw, 0);
        check("b_stat_words_cleared", b_sw, 0);
        check("b_stat_drops_cleared", b_sd, 0);
        check("b_idle_valid", b_ovalid, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    function automatic logic w_bit(input logic [7:0] pattern, input int i);
        return pattern[7-i];
    endfunction

endmodule

// File: doc/pixel_pack_word.md
Name: pixel_pack_word

Overview:
- Parametrised serial-to-parallel pixel packer.
- Accepts IN_W-bit beats under a valid/ready handshake and assembles them into OUT_W-bit words, MSB-first or LSB-first.
- Adds frame-start realignment, flush of partial words, and a registered output with backpressure.
- Sits between the bit/sub-byte pixel source and the word-wide cache/write path of the pixel processor.

Parameters:
- IN_W, 1, bits per input beat; must divide OUT_W.
- OUT_W, 16, output word width; BEATS = OUT_W/IN_W, BEATS >= 2.
- MSB_FIRST, 1, 1: first beat lands in out_data[OUT_W-1 -: IN_W]; 0: first beat lands in out_data[IN_W-1:0].

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  input beat valid.
- in_ready  out  1  packer can accept a beat this cycle.
- in_data  in  IN_W  pixel bits.
- in_sof  in  1  beat is first of a new word/frame; qualified by in_valid.
- in_flush  in  1  beat is last of a word; emit the partial word; qualified by in_valid.
- out_valid  out  1  out_data holds a word.
- out_ready  in  1  downstream accepts the word.
- out_data  out  OUT_W  packed word.
- out_cnt  out  clog2(BEATS+1)  number of valid beats in out_data.
- out_last  out  1  word was closed by in_flush.
- sync_err  out  1  one-cycle pulse: partial word discarded by in_sof.
- stat_words  out  32  statistics; see Optional Feature.
- stat_drops  out  16  statistics; see Optional Feature.

Behaviour:
- Reset (rst=1 at edge):
  - cnt=0, accumulator=0.
  - out_valid=0, out_data=0, out_cnt=0, out_last=0, sync_err=0, stat counters=0.
  - Any partial word or unaccepted output word is discarded.
- Beat acceptance: a beat is accepted on an edge with in_valid && in_ready.
- Word completion: an accepted beat completes a word if (effective cnt == BEATS-1) or in_flush.
- Output register free condition: free = !out_valid || out_ready.
- in_ready (combinational): in_ready = free || (!in_flush && cnt != BEATS-1). Non-completing beats are never stalled.
- Effective position: the beat's position is 0 if in_sof, else cnt.
- Packing:
  - MSB_FIRST=1: beat k occupies bits [OUT_W-1-k*IN_W -: IN_W].
  - MSB_FIRST=0: beat k occupies bits [k*IN_W +: IN_W].
  - Unfilled positions in a flushed word are 0.
- Completing beat:
  - On the same edge: out_data = accumulator merged with the beat, out_valid=1, out_cnt = position+1, out_last = in_flush.
  - The accumulator clears and cnt returns to 0.
- Latency: out_valid rises on the edge that accepts the completing beat (visible the next cycle).
- Non-completing beat: accumulator updated, cnt = position+1.
- Output hold and handshake:
  - out_data, out_cnt and out_last are stable while out_valid && !out_ready.
  - out_valid falls after a handshake edge unless a new word is loaded on the same edge (back-to-back words allowed).
- in_sof while cnt != 0:
  - The partial accumulator is discarded.
  - sync_err pulses for exactly 1 cycle.
  - The sof beat becomes beat 0.
- in_sof while cnt == 0: no error.
- in_sof and in_flush on the same beat: single-beat word, out_cnt=1, out_last=1.
- in_flush always carries a beat, so an empty flush cannot occur.
- in_sof/in_flush are ignored when in_valid=0 or when the beat is not accepted.
- Word counter width: cnt is max(1, clog2(BEATS)) bits; it never exceeds BEATS-1.

Optional Feature:
- Macro: PIXEL_PACK_STAT_EN.
- Defined:
  - stat_words increments on every output handshake (out_valid && out_ready); saturates at 0xFFFFFFFF.
  - stat_drops increments on every sync_err; saturates at 0xFFFF.
  - Both counters clear on rst.
- Undefined: both ports are driven constant 0 and no counter logic is generated.

Test Plan:
- IN_W=1, OUT_W=8, MSB_FIRST=1, out_ready=1, bits 1,0,1,1,0,0,1,0 -> out_data=0xB2, out_cnt=8, out_last=0, out_valid high for exactly 1 cycle, starting the cycle after the 8th beat.
- Same stimulus with MSB_FIRST=0 -> out_data=0x4D.
- IN_W=1, OUT_W=8, MSB_FIRST=1, beats 1,1,1 with in_flush on the 3rd -> out_data=0xE0, out_cnt=3, out_last=1; the next word starts at cnt=0.
- Backpressure, out_ready=0 holding 0xB2, then 8 more beats:
  - 7 beats accepted with in_ready=1.
  - On the 8th beat in_ready=0 and out_data stays 0xB2.
  - Raise out_ready for 1 cycle -> 8th beat accepted on that edge and the new word appears the following cycle.
- After 5 beats, a beat with in_sof=1 -> sync_err pulses 1 cycle, stat_drops=1 (macro on) or 0 (off); the next completed word contains the sof beat at beat 0.
- IN_W=4, OUT_W=16, nibbles A,B,C,D -> 0xABCD. Then 2 nibbles, then rst for 1 cycle -> out_valid=0, no word emitted; next 4 nibbles 1,2,3,4 -> 0x1234.
